// File: rtl/usb4_tx_pkg.sv
// Shared definitions for the transmit symbol scheduler: FSM states,
// encoder d_sel codes, speed codes and the speed-to-symbol-length map.
package usb4_tx_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_IDLE = 2'd1,
    S_DATA = 2'd2,
    S_OS   = 2'd3
  } state_e;

  localparam logic [3:0] DSEL_DATA = 4'd0;
  localparam logic [3:0] DSEL_OS   = 4'd8;
  localparam logic [3:0] DSEL_IDLE = 4'd9;

  localparam logic [1:0] SPEED_GEN0 = 2'd0;
  localparam logic [1:0] SPEED_GEN1 = 2'd1;
  localparam logic [1:0] SPEED_GEN2 = 2'd2;

  // Bytes per encoder symbol; the reserved code 3 behaves like gen 0.
  function automatic logic [4:0] sym_len(input logic [1:0] speed);
    case (speed)
      SPEED_GEN2: return 5'd8;
      SPEED_GEN1: return 5'd16;
      SPEED_GEN0: return 5'd1;
      default:    return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/tx_sym_arbiter.sv
// Boundary arbitration between the ordered-set and data sources.
// Ordered sets win by default. With TX_SCHED_FAIR_EN defined, a run
// counter of OS symbols that completed while data was waiting forces
// one data symbol once it reaches FAIR_LIMIT.
module tx_sym_arbiter
  import usb4_tx_pkg::*;
`ifdef TX_SCHED_FAIR_EN
#(
  parameter int FAIR_LIMIT = 4
)
`endif
(
`ifdef TX_SCHED_FAIR_EN
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_os_sym_end,
  input  logic   i_clear,
`endif
  input  logic   i_os_valid,
  input  logic   i_data_valid,
  output state_e o_grant
);

  logic w_fair_trip;

`ifdef TX_SCHED_FAIR_EN
  logic [3:0] r_os_run;

  // Count OS symbols that finished with data still waiting; saturate at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_os_run <= 4'd0;
    end else if (i_clear) begin
      r_os_run <= 4'd0;
    end else if (i_os_sym_end && i_data_valid && (r_os_run != 4'(FAIR_LIMIT))) begin
      r_os_run <= r_os_run + 4'd1;
    end
  end

  assign w_fair_trip = (r_os_run == 4'(FAIR_LIMIT)) && i_data_valid;
`else
  assign w_fair_trip = 1'b0;
`endif

  // Priority pick: OS unless fairness forces data, then data, else idle.
  always_comb begin
    o_grant = S_IDLE;
    if (i_os_valid && !w_fair_trip) begin
      o_grant = S_OS;
    end else if (i_data_valid) begin
      o_grant = S_DATA;
    end
  end

endmodule

// File: rtl/tx_sym_scheduler.sv
// Transmit symbol scheduler in front of the lane encoder. Grants either
// the data or the ordered-set source for one whole encoder symbol and
// drives registered, symbol-aligned encoder inputs.
// Optional feature macro: TX_SCHED_FAIR_EN (OS-vs-data fairness counter).
module tx_sym_scheduler
  import usb4_tx_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
)
(
  input  logic       i_enc_clk,
  input  logic       i_rst,
  input  logic       i_link_en,
  input  logic [1:0] i_gen_speed_cfg,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  input  logic [7:0] i_data_lane0,
  input  logic [7:0] i_data_lane1,
  input  logic       i_os_valid,
  output logic       o_os_ready,
  input  logic [7:0] i_os_lane0,
  input  logic [7:0] i_os_lane1,
  output logic       o_enable,
  output logic [3:0] o_d_sel,
  output logic [7:0] o_lane_0_tx,
  output logic [7:0] o_lane_1_tx,
  output logic [1:0] o_gen_speed,
  output logic       o_sym_start,
  output logic       o_underrun
);

  // A limit outside 1..15 cannot be represented by the 4-bit run counter.
  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_fair_limit_out_of_range
  end

  state_e     r_state;
  logic [3:0] r_byte_cnt;
  logic       r_enable;
  logic [3:0] r_d_sel;
  logic [7:0] r_lane0;
  logic [7:0] r_lane1;
  logic [1:0] r_gen_speed;
  logic       r_sym_start;
  logic       r_underrun;

  state_e     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_enable_nxt;
  logic [3:0] w_d_sel_nxt;
  logic [7:0] w_lane0_nxt;
  logic [7:0] w_lane1_nxt;
  logic [1:0] w_speed_nxt;
  logic       w_sym_start_nxt;
  logic       w_underrun_nxt;

  logic       w_active;
  logic       w_run;
  logic       w_boundary;
  logic       w_last;
  logic [4:0] w_len;
  state_e     w_grant;
  state_e     w_owner;

  assign w_active   = (r_state != S_OFF);
  assign w_run      = w_active && i_link_en;
  assign w_len      = sym_len(r_gen_speed);
  assign w_boundary = w_active && (r_byte_cnt == 4'd0);
  assign w_last     = ({1'b0, r_byte_cnt} == (w_len - 5'd1));
  assign w_owner    = w_boundary ? w_grant : r_state;

  assign o_data_ready = w_run && (w_owner == S_DATA);
  assign o_os_ready   = w_run && (w_owner == S_OS);

`ifdef TX_SCHED_FAIR_EN
  logic w_os_sym_end;
  logic w_clear;

  assign w_os_sym_end = w_run && (w_owner == S_OS) && w_last;
  assign w_clear      = w_run && w_boundary && (w_grant != S_OS);

  tx_sym_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) u_arbiter (
    .i_clk        (i_enc_clk),
    .i_rst        (i_rst),
    .i_os_sym_end (w_os_sym_end),
    .i_clear      (w_clear),
    .i_os_valid   (i_os_valid),
    .i_data_valid (i_data_valid),
    .o_grant      (w_grant)
  );
`else
  tx_sym_arbiter u_arbiter (
    .i_os_valid   (i_os_valid),
    .i_data_valid (i_data_valid),
    .o_grant      (w_grant)
  );
`endif

  // Next state, byte position and encoder byte for the coming cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_byte_cnt;
    w_enable_nxt    = 1'b0;
    w_d_sel_nxt     = DSEL_DATA;
    w_lane0_nxt     = 8'h00;
    w_lane1_nxt     = 8'h00;
    w_sym_start_nxt = 1'b0;
    w_underrun_nxt  = r_underrun;
    w_speed_nxt     = r_gen_speed;
    if (!w_active) begin
      w_cnt_nxt      = 4'd0;
      w_underrun_nxt = 1'b0;
      if (i_link_en) begin
        w_state_nxt = S_IDLE;
        w_speed_nxt = i_gen_speed_cfg;
      end else begin
        w_speed_nxt = 2'd0;
      end
    end else if (!i_link_en) begin
      w_state_nxt    = S_OFF;
      w_cnt_nxt      = 4'd0;
      w_underrun_nxt = 1'b0;
      w_speed_nxt    = 2'd0;
    end else begin
      w_state_nxt     = w_owner;
      w_enable_nxt    = 1'b1;
      w_sym_start_nxt = w_boundary;
      w_cnt_nxt       = (w_last || (w_owner == S_IDLE)) ? 4'd0 : r_byte_cnt + 4'd1;
      case (w_owner)
        S_DATA: begin
          w_d_sel_nxt = DSEL_DATA;
          if (i_data_valid) begin
            w_lane0_nxt = i_data_lane0;
            w_lane1_nxt = i_data_lane1;
          end else begin
            w_underrun_nxt = 1'b1;
          end
        end
        S_OS: begin
          w_d_sel_nxt = DSEL_OS;
          if (i_os_valid) begin
            w_lane0_nxt = i_os_lane0;
            w_lane1_nxt = i_os_lane1;
          end else begin
            w_underrun_nxt = 1'b1;
          end
        end
        default: begin
          w_d_sel_nxt = DSEL_IDLE;
        end
      endcase
    end
  end

  // State register and registered encoder outputs.
  always_ff @(posedge i_enc_clk) begin
    if (i_rst) begin
      r_state     <= S_OFF;
      r_byte_cnt  <= 4'd0;
      r_enable    <= 1'b0;
      r_d_sel     <= 4'd0;
      r_lane0     <= 8'h00;
      r_lane1     <= 8'h00;
      r_gen_speed <= 2'd0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_cnt_nxt;
      r_enable    <= w_enable_nxt;
      r_d_sel     <= w_d_sel_nxt;
      r_lane0     <= w_lane0_nxt;
      r_lane1     <= w_lane1_nxt;
      r_gen_speed <= w_speed_nxt;
      r_sym_start <= w_sym_start_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

  assign o_enable    = r_enable;
  assign o_d_sel     = r_d_sel;
  assign o_lane_0_tx = r_lane0;
  assign o_lane_1_tx = r_lane1;
  assign o_gen_speed = r_gen_speed;
  assign o_sym_start = r_sym_start;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_tx_sym_scheduler.sv
// Testbench for tx_sym_scheduler. A hand-computed vector table covers the
// reset state and single-byte symbols, a handful of directed sequences cover
// the multi-cycle cases, and a long random run is compared every cycle
// against a symbol-level reference model that counts bytes left in the
// current symbol.
module tb_tx_sym_scheduler;

  localparam int FAIR_LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       link_en = 1'b0;
  logic [1:0] cfg = 2'd0;
  logic       dv = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       ov = 1'b0;
  logic [7:0] o0 = 8'h00;
  logic [7:0] o1 = 8'h00;

  logic       data_ready;
  logic       os_ready;
  logic       enable;
  logic [3:0] d_sel;
  logic [7:0] lane0;
  logic [7:0] lane1;
  logic [1:0] gen_speed;
  logic       sym_start;
  logic       underrun;

  int checks = 0;
  int failures = 0;

  // Readies seen just before the last active edge, for directed checks.
  logic seenDr;
  logic seenOr;

  typedef struct {
    bit       rst;
    bit       link;
    bit [1:0] cfg;
    bit       dv;
    bit [7:0] d0;
    bit [7:0] d1;
    bit       ov;
    bit [7:0] o0;
    bit [7:0] o1;
    bit       chkRdy;
    bit       xDr;
    bit       xOr;
    bit       xEn;
    bit [3:0] xDsel;
    bit [7:0] xL0;
    bit [7:0] xL1;
    bit       xSs;
    bit       xUr;
    bit [1:0] xGs;
  } vec_t;

  vec_t tbl[13];

  // Reference model state: link on/off, latched speed, kind of the
  // current symbol (0 idle, 1 data, 2 OS), bytes still owed to it,
  // OS run length and the sticky underrun flag.
  bit m_on;
  int m_speed;
  int m_kind;
  int m_left;
  int m_run;
  bit m_underrun;

  bit eDr, eOr, eEn, eSs, eUr;
  int eDsel, eL0, eL1, eGs;

  tx_sym_scheduler #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
    .i_enc_clk       (clk),
    .i_rst           (rst),
    .i_link_en       (link_en),
    .i_gen_speed_cfg (cfg),
    .i_data_valid    (dv),
    .o_data_ready    (data_ready),
    .i_data_lane0    (d0),
    .i_data_lane1    (d1),
    .i_os_valid      (ov),
    .o_os_ready      (os_ready),
    .i_os_lane0      (o0),
    .i_os_lane1      (o1),
    .o_enable        (enable),
    .o_d_sel         (d_sel),
    .o_lane_0_tx     (lane0),
    .o_lane_1_tx     (lane1),
    .o_gen_speed     (gen_speed),
    .o_sym_start     (sym_start),
    .o_underrun      (underrun)
  );

  // Free-running encoder byte clock.
  always #5 clk = ~clk;

  function automatic int lenOf(input int s);
    return (s == 2) ? 8 : ((s == 1) ? 16 : 1);
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit trip;
    bit vld;
    int len;
    eDr = 0; eOr = 0; eEn = 0; eSs = 0; eDsel = 0; eL0 = 0; eL1 = 0;
    trip = 0;
    vld = 0;
    len = lenOf(m_speed);
    if (rst) begin
      m_on = 0; m_left = 0; m_run = 0; m_underrun = 0; m_speed = 0;
    end else if (!m_on) begin
      m_underrun = 0;
      m_left = 0;
      m_speed = link_en ? int'(cfg) : 0;
      m_on = link_en;
    end else if (!link_en) begin
      m_on = 0; m_left = 0; m_underrun = 0; m_speed = 0;
    end else begin
      eEn = 1;
      if (m_left == 0) begin
`ifdef TX_SCHED_FAIR_EN
        trip = (m_run >= FAIR_LIMIT) && dv;
`endif
        if (ov && !trip) m_kind = 2;
        else if (dv) m_kind = 1;
        else m_kind = 0;
        eSs = 1;
        if (m_kind != 2) m_run = 0;
        m_left = (m_kind == 0) ? 1 : len;
      end
      if (m_kind == 0) begin
        eDsel = 9;
      end else begin
        eDsel = (m_kind == 1) ? 0 : 8;
        eDr = (m_kind == 1);
        eOr = (m_kind == 2);
        vld = (m_kind == 1) ? dv : ov;
        if (vld) begin
          eL0 = (m_kind == 1) ? int'(d0) : int'(o0);
          eL1 = (m_kind == 1) ? int'(d1) : int'(o1);
        end else begin
          m_underrun = 1;
        end
      end
      m_left--;
      if (m_kind == 2 && m_left == 0 && dv && m_run < FAIR_LIMIT) m_run++;
    end
    eGs = m_speed;
    eUr = m_underrun;
  endtask

  task automatic checkOutput(input string tag, input bit xEn, input int xDsel, input int xL0,
                             input int xL1, input bit xSs, input bit xUr, input int xGs);
    checkField({tag, "_enable"}, 32'(enable), 32'(xEn));
    checkField({tag, "_d_sel"}, 32'(d_sel), 32'(xDsel));
    checkField({tag, "_lane0"}, 32'(lane0), 32'(xL0));
    checkField({tag, "_lane1"}, 32'(lane1), 32'(xL1));
    checkField({tag, "_sym_start"}, 32'(sym_start), 32'(xSs));
    checkField({tag, "_underrun"}, 32'(underrun), 32'(xUr));
    checkField({tag, "_gen_speed"}, 32'(gen_speed), 32'(xGs));
  endtask

  // One clock: drive at the falling edge, check readies before the rising
  // edge, check registered outputs 1 time unit after it.
  task automatic applyStimulus(input vec_t v, input bit fromTable, input string tag);
    @(negedge clk);
    rst = v.rst; link_en = v.link; cfg = v.cfg;
    dv = v.dv; d0 = v.d0; d1 = v.d1;
    ov = v.ov; o0 = v.o0; o1 = v.o1;
    #1;
    seenDr = data_ready;
    seenOr = os_ready;
    modelStep();
    if (fromTable) begin
      if (v.chkRdy) begin
        checkField({tag, "_data_ready"}, 32'(data_ready), 32'(v.xDr));
        checkField({tag, "_os_ready"}, 32'(os_ready), 32'(v.xOr));
      end
    end else if (!v.rst) begin
      checkField({tag, "_data_ready"}, 32'(data_ready), 32'(eDr));
      checkField({tag, "_os_ready"}, 32'(os_ready), 32'(eOr));
    end
    @(posedge clk);
    #1;
    if (fromTable)
      checkOutput(tag, v.xEn, int'(v.xDsel), int'(v.xL0), int'(v.xL1), v.xSs, v.xUr, int'(v.xGs));
    else
      checkOutput(tag, eEn, eDsel, eL0, eL1, eSs, eUr, eGs);
  endtask

  function automatic vec_t mkIn(input bit r, input bit l, input bit [1:0] c, input bit dvv,
                                input bit [7:0] a, input bit [7:0] b, input bit ovv,
                                input bit [7:0] x, input bit [7:0] y);
    vec_t v;
    v = '{r, l, c, dvv, a, b, ovv, x, y, 0, 0, 0, 0, 4'd0, 8'd0, 8'd0, 0, 0, 2'd0};
    return v;
  endfunction

  // Stimulus sequence: table, directed sequences, random run, summary.
  initial begin
    int ssCount;
    int ssFirst;
    int ssSecond;
    int drCount;
    int orCount;
    int dataSyms;
    int osSyms;
    bit [7:0] ssBytes[$];

    // Gen 0/3: every byte is its own symbol, so each row is hand-checkable.
    tbl[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 2'd0};
    tbl[1]  = '{0, 1, 3, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 2'd3};
    tbl[2]  = '{0, 1, 0, 1, 8'hA1, 8'hB1, 0, 8'h00, 8'h00, 1, 1, 0, 1, 4'd0, 8'hA1, 8'hB1, 1, 0, 2'd3};
    tbl[3]  = '{0, 1, 0, 1, 8'hA2, 8'hB2, 1, 8'hC2, 8'hD2, 1, 0, 1, 1, 4'd8, 8'hC2, 8'hD2, 1, 0, 2'd3};
    tbl[4]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 4'd9, 8'h00, 8'h00, 1, 0, 2'd3};
    tbl[5]  = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 8'hE4, 8'hF4, 1, 0, 1, 1, 4'd8, 8'hE4, 8'hF4, 1, 0, 2'd3};
    tbl[6]  = '{0, 0, 0, 1, 8'h55, 8'h66, 1, 8'h77, 8'h88, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 2'd0};
    tbl[7]  = '{0, 0, 0, 1, 8'h55, 8'h66, 1, 8'h77, 8'h88, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 2'd0};
    tbl[8]  = '{1, 1, 2, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 2'd0};
    tbl[9]  = '{0, 1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 2'd1};
    tbl[10] = '{0, 1, 2, 1, 8'h11, 8'h22, 0, 8'h00, 8'h00, 1, 1, 0, 1, 4'd0, 8'h11, 8'h22, 1, 0, 2'd1};
    tbl[11] = '{0, 1, 2, 0, 8'h33, 8'h44, 1, 8'h99, 8'h99, 1, 1, 0, 1, 4'd0, 8'h00, 8'h00, 0, 1, 2'd1};
    tbl[12] = '{0, 1, 2, 1, 8'h33, 8'h44, 1, 8'h99, 8'h99, 1, 1, 0, 1, 4'd0, 8'h33, 8'h44, 0, 1, 2'd1};
    for (int i = 0; i < 13; i++) applyStimulus(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Gen 2 continuous data 0x01..0x10: two 8-byte symbols.
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "seqA_rst");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 0, 0, 0), 0, "seqA_on");
    ssBytes.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(mkIn(0, 1, 2, 1, 8'(i + 1), 8'(8'h80 + i + 1), 0, 0, 0), 0, "seqA");
      if (sym_start) ssBytes.push_back(lane0);
    end
    checkField("seqA_ss_count", 32'(ssBytes.size()), 32'd2);
    if (ssBytes.size() == 2) begin
      checkField("seqA_ss_byte0", 32'(ssBytes[0]), 32'h01);
      checkField("seqA_ss_byte1", 32'(ssBytes[1]), 32'h09);
    end
    checkField("seqA_underrun", 32'(underrun), 32'd0);

    // Gen 1 with both valids: 16 OS bytes, data only after os_valid drops.
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "seqB_rst");
    applyStimulus(mkIn(0, 1, 1, 0, 0, 0, 0, 0, 0), 0, "seqB_on");
    drCount = 0;
    orCount = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(mkIn(0, 1, 1, 1, 8'h5A, 8'hA5, 1, 8'(i), 8'(~i)), 0, "seqB_os");
      drCount += int'(seenDr);
      orCount += int'(seenOr);
    end
    checkField("seqB_data_ready_count", 32'(drCount), 32'd0);
    checkField("seqB_os_ready_count", 32'(orCount), 32'd16);
    applyStimulus(mkIn(0, 1, 1, 1, 8'h5A, 8'hA5, 0, 0, 0), 0, "seqB_data");
    checkField("seqB_data_granted", 32'(seenDr), 32'd1);
    checkField("seqB_data_dsel", 32'(d_sel), 32'd0);
    for (int i = 0; i < 15; i++) applyStimulus(mkIn(0, 1, 1, 1, 8'(i), 8'(i), 1, 0, 0), 0, "seqB_tail");

    // Gen 2 with both valids held: fairness pattern, or OS only without it.
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "seqC_rst");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 0, 0, 0), 0, "seqC_on");
    dataSyms = 0;
    osSyms = 0;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(mkIn(0, 1, 2, 1, 8'h10, 8'h20, 1, 8'h30, 8'h40), 0, "seqC");
      if (sym_start && d_sel == 4'd0) dataSyms++;
      if (sym_start && d_sel == 4'd8) osSyms++;
    end
`ifdef TX_SCHED_FAIR_EN
    checkField("seqC_data_symbols", 32'(dataSyms), 32'd3);
    checkField("seqC_os_symbols", 32'(osSyms), 32'd12);
`else
    checkField("seqC_data_symbols", 32'(dataSyms), 32'd0);
    checkField("seqC_os_symbols", 32'(osSyms), 32'd15);
`endif

    // Gen 2 data symbol starved on byte 3: pad, underrun, full length kept.
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "seqD_rst");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 0, 0, 0), 0, "seqD_on");
    ssFirst = -1;
    ssSecond = -1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(mkIn(0, 1, 2, k != 2, 8'(8'hC0 + k), 8'(8'hD0 + k), 0, 0, 0), 0, "seqD");
      if (k == 2) begin
        checkField("seqD_pad_lane0", 32'(lane0), 32'h00);
        checkField("seqD_pad_lane1", 32'(lane1), 32'h00);
        checkField("seqD_pad_underrun", 32'(underrun), 32'd1);
      end
      if (sym_start && ssFirst < 0) ssFirst = k;
      else if (sym_start && ssSecond < 0) ssSecond = k;
    end
    checkField("seqD_symbol_spacing", 32'(ssSecond - ssFirst), 32'd8);
    checkField("seqD_underrun_sticky", 32'(underrun), 32'd1);

    // link_en dropped on byte 5 of a gen 1 symbol, then re-enabled at gen 0.
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "seqE_rst");
    applyStimulus(mkIn(0, 1, 1, 0, 0, 0, 0, 0, 0), 0, "seqE_on");
    for (int i = 0; i < 4; i++) applyStimulus(mkIn(0, 1, 1, 1, 8'(i + 1), 8'(i + 1), 0, 0, 0), 0, "seqE_data");
    applyStimulus(mkIn(0, 0, 1, 1, 8'h05, 8'h05, 0, 0, 0), 0, "seqE_drop");
    checkField("seqE_drop_ready", 32'(seenDr), 32'd0);
    checkField("seqE_drop_enable", 32'(enable), 32'd0);
    checkField("seqE_drop_lane0", 32'(lane0), 32'd0);
    applyStimulus(mkIn(0, 1, 0, 0, 0, 0, 0, 0, 0), 0, "seqE_reon");
    ssCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mkIn(0, 1, 0, 1, 8'(i), 8'(i), i[0], 8'hEE, 8'hEF), 0, "seqE_gen0");
      ssCount += int'(sym_start);
    end
    checkField("seqE_gen0_sym_starts", 32'(ssCount), 32'd6);

    // Reset in the middle of an OS symbol with underrun already set.
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "seqF_rst");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 0, 0, 0), 0, "seqF_on");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 1, 8'h71, 8'h72), 0, "seqF_os");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 1, 8'h73, 8'h74), 0, "seqF_os");
    applyStimulus(mkIn(0, 1, 2, 0, 0, 0, 0, 0, 0), 0, "seqF_pad");
    checkField("seqF_underrun_set", 32'(underrun), 32'd1);
    applyStimulus(mkIn(1, 1, 2, 1, 0, 0, 1, 0, 0), 0, "seqF_midrst");
    checkField("seqF_enable", 32'(enable), 32'd0);
    checkField("seqF_underrun_clr", 32'(underrun), 32'd0);
    checkField("seqF_gen_speed", 32'(gen_speed), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      vec_t v;
      v = mkIn(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) != 0), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
      applyStimulus(v, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
